pc_seq: RTL and testbench
=========================

PC_SEQ -- requirements
Module: pc_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, which sets the address width.
REQ-002 The block SHALL have parameter DEPTH, default 4, which sets the number of return-stack entries.
REQ-003 clk  input  1  clock; reset reset, synchronous, active-high; clock clk.
REQ-004 reset  input  1  synchronous active-high reset.
REQ-005 run  input  1  high permits instruction fetching.
REQ-006 crnt_adr  input  WIDTH  current program-counter value.
REQ-007 pc_enable  output  1  one-cycle increment strobe to the PC.
REQ-008 pc_load  output  1  one-cycle load strobe to the PC.
REQ-009 pc_nxt_adr  output  WIDTH  load address; all-zero when pc_load=0.
REQ-010 imem_req  output  1  instruction-memory fetch request.
REQ-011 imem_ack  input  1  fetch completes on the cycle it is high with imem_req.
REQ-012 instr_valid  output  1  fetched instruction is available.
REQ-013 instr_ready  input  1  consumer accepts the instruction.
REQ-014 br_valid  input  1  branch request.
REQ-015 br_kind  input  2  00 jump, 01 call, 10 return, 11 treated as jump.
REQ-016 br_target  input  WIDTH  branch target.
REQ-017 br_ready  output  1  branch accepted this cycle.
REQ-018 stk_err  output  1  sticky return-stack overflow/underflow flag.

Function
REQ-019 The FSM SHALL have the states IDLE, FETCH and HOLD; all outputs SHALL be decoded from the state register plus current inputs, with no added register latency.
REQ-020 IDLE: all strobes low; run=1 SHALL move the FSM to FETCH on the next edge.
REQ-021 FETCH: imem_req=1; imem_ack=1 SHALL move the FSM to HOLD; run falling in FETCH SHALL NOT abort the fetch.
REQ-022 HOLD: instr_valid=1; without instr_ready the state and all strobes SHALL hold.
REQ-023 HOLD, instr_ready=1, br_valid=0: pc_enable=1 for that cycle.
REQ-024 HOLD, instr_ready=1, br_valid=1: pc_load=1 and br_ready=1 for that cycle.
REQ-025 With the REQ-024 load, pc_nxt_adr SHALL be br_target for jump/call, or the popped stack top for return.
REQ-026 br_valid SHALL be ignored while not in HOLD or while instr_ready=0; br_ready=0 in those cycles.
REQ-027 After a HOLD completes, the next state SHALL be FETCH if run=1, else IDLE.
REQ-028 Call SHALL push crnt_adr+1, computed modulo 2^WIDTH (all-ones wraps to zero).
REQ-029 Call on a full stack SHALL drop the push, set stk_err and still take the jump.
REQ-030 Return on an empty stack SHALL load all-zero and set stk_err.
REQ-031 A push and a pop never coincide, since one branch is accepted per cycle.

Reset
REQ-032 reset SHALL take priority over all inputs; on the next edge state=IDLE, stack pointer=0 and stk_err=0.
REQ-033 After reset every output SHALL be 0, including pc_nxt_adr.
REQ-034 reset asserted mid-FETCH or mid-HOLD SHALL abandon the transaction; a late imem_ack SHALL be ignored.

Configuration
REQ-035 With macro PC_SEQ_STACK_EN defined, the return stack and the call/return behaviour SHALL be built.
REQ-036 Without PC_SEQ_STACK_EN, call and return SHALL behave as jump to br_target, stk_err SHALL be tied 0 and no stack storage SHALL exist.

Structure
REQ-037 Package pc_seq_pkg SHALL hold the state encoding and the br_kind constants BR_JUMP, BR_CALL, BR_RET.
REQ-038 The return stack SHALL be sub-module pc_ras with ports push, pop, din, dout, full, empty, parameterised by WIDTH and DEPTH.

Verification
REQ-039 reset=1 for 2 cycles, then run=1 -> cycle 1 in FETCH with imem_req=1; all outputs 0 during reset.
REQ-040 crnt_adr=8'h05, ack, instr_ready=1, br_valid=0 -> single pc_enable pulse, FSM back to FETCH.
REQ-041 crnt_adr=8'h10, call to 8'h40 -> pc_load with nxt_adr=8'h40; later return -> pc_load with nxt_adr=8'h11.
REQ-042 crnt_adr=8'hFF, call -> pushed value 8'h00; return from empty stack -> nxt_adr=8'h00 and stk_err=1 until reset.
REQ-043 DEPTH=4 with 5 calls -> stk_err=1; 4 returns yield the first 4 pushed addresses in LIFO order.
REQ-044 Hold instr_ready=0 for 3 cycles with br_valid=1 -> br_ready=0 and instr_valid=1 throughout; run=0 after acceptance -> IDLE.

Source files
------------

// File: rtl/pc_seq_pkg.sv
// Shared types for the PC sequencer: FSM encoding and branch-kind codes.
// Imported by pc_seq and pc_ras.
package pc_seq_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_FETCH = 2'b01,
        S_HOLD  = 2'b10
    } state_t;

    localparam logic [1:0] BR_JUMP = 2'b00;
    localparam logic [1:0] BR_CALL = 2'b01;
    localparam logic [1:0] BR_RET  = 2'b10;

    // Kind 2'b11 falls through both helpers and so behaves as a jump.
    function automatic logic is_call(input logic [1:0] kind);
        return kind == BR_CALL;
    endfunction

    function automatic logic is_ret(input logic [1:0] kind);
        return kind == BR_RET;
    endfunction

endpackage

// File: rtl/pc_ras.sv
// Return-address stack for pc_seq; dout shows the top entry, zero when empty.
// push and pop are never asserted together by the sequencer.
module pc_ras
    import pc_seq_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int PW = $clog2(DEPTH + 1);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_sp;
    logic [AW-1:0]    w_top;
    logic [AW-1:0]    w_wr;
    logic             w_do_push;
    logic             w_do_pop;

    assign full      = (r_sp == PW'(DEPTH));
    assign empty     = (r_sp == '0);
    assign w_top     = AW'(r_sp - 1'b1);
    assign w_wr      = AW'(r_sp);
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;
    assign dout      = empty ? '0 : r_mem[w_top];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sp <= '0;
        end else if (w_do_push) begin
            r_sp <= r_sp + 1'b1;
        end else if (w_do_pop) begin
            r_sp <= r_sp - 1'b1;
        end
    end

    // Storage needs no reset: entries above the pointer are never read.
    always_ff @(posedge clk) begin
        if (!reset && w_do_push) begin
            r_mem[w_wr] <= din;
        end
    end

endmodule

// File: rtl/pc_seq.sv
// Fetch/branch sequencer driving PC increment/load strobes.
// Define PC_SEQ_STACK_EN to build the call/return stack.
module pc_seq
    import pc_seq_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic [WIDTH-1:0] crnt_adr,
    output logic             pc_enable,
    output logic             pc_load,
    output logic [WIDTH-1:0] pc_nxt_adr,
    output logic             imem_req,
    input  logic             imem_ack,
    output logic             instr_valid,
    input  logic             instr_ready,
    input  logic             br_valid,
    input  logic [1:0]       br_kind,
    input  logic [WIDTH-1:0] br_target,
    output logic             br_ready,
    output logic             stk_err
);

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] w_load_adr;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (run) w_next = S_FETCH;
            end
            S_FETCH: begin
                if (imem_ack) w_next = S_HOLD;
            end
            S_HOLD: begin
                if (instr_ready) w_next = run ? S_FETCH : S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Outputs are forced low while reset is held so nothing leaks out
    // of an abandoned fetch or hold.
    always_comb begin
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        pc_enable   = 1'b0;
        pc_load     = 1'b0;
        br_ready    = 1'b0;
        if (!reset) begin
            unique case (r_state)
                S_FETCH: imem_req = 1'b1;
                S_HOLD: begin
                    instr_valid = 1'b1;
                    pc_enable   = instr_ready && !br_valid;
                    pc_load     = instr_ready && br_valid;
                    br_ready    = instr_ready && br_valid;
                end
                default: ;
            endcase
        end
    end

    assign pc_nxt_adr = pc_load ? w_load_adr : '0;

`ifdef PC_SEQ_STACK_EN
    logic             w_push;
    logic             w_pop;
    logic             w_full;
    logic             w_empty;
    logic [WIDTH-1:0] w_top;
    logic [WIDTH-1:0] w_ret_adr;
    logic             w_err_set;
    logic             r_stk_err;

    assign w_ret_adr = crnt_adr + 1'b1;
    assign w_push    = pc_load && is_call(br_kind) && !w_full;
    assign w_pop     = pc_load && is_ret(br_kind) && !w_empty;
    assign w_err_set = pc_load &&
                       ((is_call(br_kind) && w_full) ||
                        (is_ret(br_kind) && w_empty));

    pc_ras #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ras (
        .clk   (clk),
        .reset (reset),
        .push  (w_push),
        .pop   (w_pop),
        .din   (w_ret_adr),
        .dout  (w_top),
        .full  (w_full),
        .empty (w_empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stk_err <= 1'b0;
        end else if (w_err_set) begin
            r_stk_err <= 1'b1;
        end
    end

    // An empty stack presents zero on w_top, giving the all-zero load.
    assign w_load_adr = is_ret(br_kind) ? w_top : br_target;
    assign stk_err    = r_stk_err;
`else
    logic w_unused_ok;

    assign w_unused_ok = ^{br_kind, crnt_adr};
    assign w_load_adr  = br_target;
    assign stk_err     = 1'b0;
`endif

endmodule

// File: tb/tb_pc_seq.sv
// Directed vector bench for pc_seq (WIDTH=8, DEPTH=4).
// Expectations follow the PC_SEQ_STACK_EN build setting.
module tb_pc_seq;

`ifdef PC_SEQ_STACK_EN
    localparam bit S = 1'b1;
`else
    localparam bit S = 1'b0;
`endif

    localparam logic [1:0] J = 2'b00;
    localparam logic [1:0] C = 2'b01;
    localparam logic [1:0] R = 2'b10;
    localparam logic [1:0] X = 2'b11;

    logic       clk = 1'b0;
    logic       reset;
    logic       run;
    logic [7:0] crnt_adr;
    logic       pc_enable;
    logic       pc_load;
    logic [7:0] pc_nxt_adr;
    logic       imem_req;
    logic       imem_ack;
    logic       instr_valid;
    logic       instr_ready;
    logic       br_valid;
    logic [1:0] br_kind;
    logic [7:0] br_target;
    logic       br_ready;
    logic       stk_err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pc_seq #(
        .WIDTH (8),
        .DEPTH (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .run         (run),
        .crnt_adr    (crnt_adr),
        .pc_enable   (pc_enable),
        .pc_load     (pc_load),
        .pc_nxt_adr  (pc_nxt_adr),
        .imem_req    (imem_req),
        .imem_ack    (imem_ack),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .br_valid    (br_valid),
        .br_kind     (br_kind),
        .br_target   (br_target),
        .br_ready    (br_ready),
        .stk_err     (stk_err)
    );

    typedef struct {
        logic       run, ack, rdy, bv;
        logic [1:0] kind;
        logic [7:0] tgt, adr;
        logic       req, val, en, ld, brr, err;
        logic [7:0] nxt;
    } vec_t;

    vec_t tv[$];

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", nm, got, exp);
        end
    endtask

    function automatic logic [13:0] obs();
        return {imem_req, instr_valid, pc_enable, pc_load,
                br_ready, stk_err, pc_nxt_adr};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic a, input logic rd,
                         input logic b, input logic [1:0] k,
                         input logic [7:0] t, input logic [7:0] ad);
        run = r; imem_ack = a; instr_ready = rd; br_valid = b;
        br_kind = k; br_target = t; crnt_adr = ad;
    endtask

    task automatic add(input logic r, input logic a, input logic rd,
                       input logic b, input logic [1:0] k,
                       input logic [7:0] t, input logic [7:0] ad,
                       input logic q, input logic v, input logic e,
                       input logic l, input logic br, input logic er,
                       input logic [7:0] n);
        vec_t x;
        x.run = r; x.ack = a; x.rdy = rd; x.bv = b; x.kind = k;
        x.tgt = t; x.adr = ad; x.req = q; x.val = v; x.en = e;
        x.ld = l; x.brr = br; x.err = er; x.nxt = n;
        tv.push_back(x);
    endtask

    // FETCH -> HOLD, then present one accepted branch and check the load.
    task automatic br(input logic [1:0] k, input logic [7:0] t,
                      input logic [7:0] ad, input logic [7:0] exp,
                      input string nm);
        drive(1, 1, 0, 0, J, 8'h00, 8'h00);
        tick();
        drive(1, 0, 1, 1, k, t, ad);
        #2;
        chk(nm, {pc_load, br_ready, pc_nxt_adr}, {2'b11, exp});
        tick();
        drive(1, 0, 0, 0, J, 8'h00, 8'h00);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(0, 0, 0, 0, J, 8'h00, 8'h00);
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        //   run ack rdy bv kind tgt    adr  | req val en ld brr err nxt
        add(1, 0, 0, 0, J, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 8'h00);
        add(1, 0, 0, 0, J, 8'h00, 8'h00, 1, 0, 0, 0, 0, 0, 8'h00);
        add(0, 1, 0, 0, J, 8'h00, 8'h00, 1, 0, 0, 0, 0, 0, 8'h00);
        add(1, 0, 0, 1, J, 8'h33, 8'h05, 0, 1, 0, 0, 0, 0, 8'h00);
        add(1, 0, 1, 0, J, 8'h33, 8'h05, 0, 1, 1, 0, 0, 0, 8'h00);
        add(1, 1, 0, 0, J, 8'h00, 8'h10, 1, 0, 0, 0, 0, 0, 8'h00);
        add(1, 0, 1, 1, C, 8'h40, 8'h10, 0, 1, 0, 1, 1, 0, 8'h40);
        add(1, 1, 0, 0, J, 8'h00, 8'h40, 1, 0, 0, 0, 0, 0, 8'h00);
        add(1, 0, 1, 1, R, 8'h77, 8'h40, 0, 1, 0, 1, 1, 0,
            S ? 8'h11 : 8'h77);
        add(1, 1, 0, 0, J, 8'h00, 8'hFF, 1, 0, 0, 0, 0, 0, 8'h00);
        add(1, 0, 1, 1, C, 8'h20, 8'hFF, 0, 1, 0, 1, 1, 0, 8'h20);
        add(1, 1, 0, 0, J, 8'h00, 8'h20, 1, 0, 0, 0, 0, 0, 8'h00);
        add(1, 0, 1, 1, R, 8'h55, 8'h20, 0, 1, 0, 1, 1, 0,
            S ? 8'h00 : 8'h55);
        add(1, 1, 0, 0, J, 8'h00, 8'h00, 1, 0, 0, 0, 0, 0, 8'h00);
        add(0, 0, 1, 1, R, 8'h66, 8'h00, 0, 1, 0, 1, 1, 0,
            S ? 8'h00 : 8'h66);
        add(0, 0, 0, 0, J, 8'h00, 8'h00, 0, 0, 0, 0, 0, S, 8'h00);
        add(0, 0, 1, 1, J, 8'h12, 8'h00, 0, 0, 0, 0, 0, S, 8'h00);
        add(1, 0, 0, 0, J, 8'h00, 8'h00, 0, 0, 0, 0, 0, S, 8'h00);
        add(1, 1, 1, 1, J, 8'h12, 8'h00, 1, 0, 0, 0, 0, S, 8'h00);
        add(0, 0, 1, 1, X, 8'h9A, 8'h00, 0, 1, 0, 1, 1, S, 8'h9A);

        reset = 1'b1;
        drive(1, 0, 0, 0, J, 8'h00, 8'h00);
        tick();
        chk("rst_c1", obs(), 14'h0);
        tick();
        chk("rst_c2", obs(), 14'h0);
        reset = 1'b0;

        foreach (tv[i]) begin
            drive(tv[i].run, tv[i].ack, tv[i].rdy, tv[i].bv,
                  tv[i].kind, tv[i].tgt, tv[i].adr);
            #2;
            chk($sformatf("vec%0d", i), obs(),
                {tv[i].req, tv[i].val, tv[i].en, tv[i].ld,
                 tv[i].brr, tv[i].err, tv[i].nxt});
            tick();
        end

        do_reset();
        chk("err_clr", obs(), 14'h0);

        // Reset in the middle of a fetch; the late ack must be ignored.
        drive(1, 0, 0, 0, J, 8'h00, 8'h00);
        tick();
        chk("mid_fetch", imem_req, 1);
        reset = 1'b1;
        drive(1, 1, 0, 0, J, 8'h00, 8'h00);
        #2;
        chk("rst_fetch_out", obs(), 14'h0);
        tick();
        reset = 1'b0;
        drive(0, 1, 0, 0, J, 8'h00, 8'h00);
        #2;
        chk("late_ack", {imem_req, instr_valid}, 2'b00);
        tick();
        chk("late_ack2", {imem_req, instr_valid}, 2'b00);

        // Reset in the middle of a hold.
        drive(1, 0, 0, 0, J, 8'h00, 8'h00);
        tick();
        drive(1, 1, 0, 0, J, 8'h00, 8'h00);
        tick();
        chk("mid_hold", instr_valid, 1);
        reset = 1'b1;
        drive(1, 0, 1, 1, J, 8'h44, 8'h00);
        #2;
        chk("rst_hold_out", obs(), 14'h0);
        tick();
        reset = 1'b0;
        drive(0, 0, 0, 0, J, 8'h00, 8'h00);
        #2;
        chk("hold_gone", {imem_req, instr_valid}, 2'b00);

        // Overflow with DEPTH=4, then LIFO drain and underflow.
        do_reset();
        drive(1, 0, 0, 0, J, 8'h00, 8'h00);
        tick();
        for (int i = 0; i < 4; i++) begin
            br(C, 8'h50 + 8'(i), 8'hA0 + 8'(i), 8'h50 + 8'(i),
               $sformatf("call%0d", i));
        end
        chk("err_after4", stk_err, 0);
        br(C, 8'h54, 8'hA4, 8'h54, "call4");
        chk("err_ovf", stk_err, S);
        for (int i = 0; i < 4; i++) begin
            br(R, 8'h60 + 8'(i), 8'h00,
               S ? (8'hA4 - 8'(i)) : (8'h60 + 8'(i)),
               $sformatf("ret%0d", i));
        end
        br(R, 8'h64, 8'h00, S ? 8'h00 : 8'h64, "ret_empty");
        chk("err_unf", stk_err, S);

        // Branch stalled behind instr_ready, then accept with run low.
        do_reset();
        drive(1, 0, 0, 0, J, 8'h00, 8'h00);
        tick();
        drive(1, 1, 0, 0, J, 8'h00, 8'h00);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 0, 1, J, 8'h88, 8'h00);
            #2;
            chk($sformatf("stall%0d", i),
                {instr_valid, br_ready, pc_load, pc_enable}, 4'b1000);
            tick();
        end
        drive(0, 0, 1, 1, J, 8'h88, 8'h00);
        #2;
        chk("stall_acc", {br_ready, pc_load, pc_nxt_adr}, {2'b11, 8'h88});
        tick();
        drive(0, 0, 0, 0, J, 8'h00, 8'h00);
        #2;
        chk("to_idle", {imem_req, instr_valid}, 2'b00);
        tick();
        chk("idle_stay", {imem_req, instr_valid}, 2'b00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
